// File: rtl/gauss_window_3x3_pkg.sv
// rtl/gauss_window_3x3_pkg.sv - shared constants and types for the 3x3 Gaussian filter datapath
package gauss_pkg;

  localparam int PIX_W = 8;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/gauss_window_3x3_if.sv
// rtl/gauss_window_3x3_if.sv - pixel stream in, 3x3 window out
interface gauss_window_3x3_if #(
  parameter int PIX_W = gauss_pkg::PIX_W
);

  logic             pix_valid;
  logic             sof;
  logic [PIX_W-1:0] pix_in;
  logic             win_valid;
  logic             win_last;
  logic [PIX_W-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;

  // Source side: drives pixels, observes windows
  modport master (
    output pix_valid, sof, pix_in,
    input  win_valid, win_last, w1, w2, w3, w4, w5, w6, w7, w8, w9
  );

  // Window generator side
  modport slave (
    input  pix_valid, sof, pix_in,
    output win_valid, win_last, w1, w2, w3, w4, w5, w6, w7, w8, w9
  );

endinterface

// File: rtl/gauss_window_3x3_line_delay.sv
// rtl/gauss_window_3x3_line_delay.sv - enable-advanced circular buffer giving a DEPTH-beat delay
module line_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;

  // The slot about to be overwritten holds the sample written DEPTH beats ago
  assign dout = mem_q[ptr_q];

  // Pointer advances one slot per enabled beat and wraps at DEPTH-1
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  // Pointer register; contents need no reset because stale data never reaches a valid window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Write after the combinational read at the same address
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/gauss_window_3x3.sv
// rtl/gauss_window_3x3.sv - raster stream to 3x3 neighbourhood window generator
module gauss_window_3x3 #(
  parameter int PIX_W = gauss_pkg::PIX_W,
  parameter int IMG_W = gauss_pkg::IMG_W,
  parameter int IMG_H = gauss_pkg::IMG_H
) (
  input logic               clk,
  input logic               rst,
  gauss_window_3x3_if.slave bus
);

  import gauss_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] win_d [3][3];
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;

  logic             accept;
  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic             at_last;
  logic [PIX_W-1:0] buf0_out;
  logic [PIX_W-1:0] buf1_out;

  // buf0 delays the current line by one row, buf1 by two
  line_delay #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_buf0 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (bus.pix_in),
    .dout (buf0_out)
  );

  line_delay #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_buf1 (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .din  (buf0_out),
    .dout (buf1_out)
  );

  // Beat acceptance, raster position of this pixel, window shift and next state
  always_comb begin
    accept  = bus.pix_valid && ((state_q == RUN) || bus.sof);
    cur_col = bus.sof ? '0 : col_q;
    cur_row = bus.sof ? '0 : row_q;
    at_last = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));

    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;

    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = buf1_out;
      win_d[1][2] = buf0_out;
      win_d[2][2] = bus.pix_in;

      win_valid_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      win_last_d  = at_last;

      if (at_last) begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = RUN;
        if (cur_col == CW'(IMG_W - 1)) begin
          col_d = '0;
          row_d = cur_row + RW'(1);
        end else begin
          col_d = cur_col + CW'(1);
          row_d = cur_row;
        end
      end
    end
  end

  // FSM, counters, window array and output flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_q       <= win_d;
    end
  end

  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;
  assign bus.w1 = win_q[0][0];
  assign bus.w2 = win_q[0][1];
  assign bus.w3 = win_q[0][2];
  assign bus.w4 = win_q[1][0];
  assign bus.w5 = win_q[1][1];
  assign bus.w6 = win_q[1][2];
  assign bus.w7 = win_q[2][0];
  assign bus.w8 = win_q[2][1];
  assign bus.w9 = win_q[2][2];

endmodule
